lsu_subword_bridge: RTL

- Load/store unit that sits directly upstream of memory_integrated and drives its addressVirt/dataInVirt/wEnVirt inputs while consuming dataOutVirt.
- Accepts byte, halfword and word requests from the CPU memory stage.
- Performs aligned word accesses directly. Performs sub-word stores as read-modify-write.
- Sign- or zero-extends sub-word loads, and flags misaligned requests without touching memory.

---
 rtl/lsu_subword_bridge.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_subword_bridge.sv
// Load/store bridge between the CPU memory stage and memory_integrated: word/half/byte
// access, read-modify-write sub-word stores. Optional macro LSU_UNMAPPED_CHECK_EN.
module lsu_subword_bridge #(
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] addressVirt,
    output logic [31:0] dataInVirt,
    output logic        wEnVirt,
    input  logic [31:0] dataOutVirt
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    localparam logic [1:0] RELOAD = 2'(MEM_RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic unmapped(input logic [31:0] a);
`ifdef LSU_UNMAPPED_CHECK_EN
        unmapped = !(!a[31] || (a >= 32'hFFFF_0000 && a <= 32'hFFFF_FF07));
`else
        unmapped = 1'b0 & a[0];
`endif
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   extract = {{24{sgn & b[7]}}, b};
            2'b01:   extract = {{16{sgn & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
        merge = w;
        if (size == 2'b00) begin
            case (off)
                2'd0:    merge[7:0]   = wd[7:0];
                2'd1:    merge[15:8]  = wd[7:0];
                2'd2:    merge[23:16] = wd[7:0];
                default: merge[31:24] = wd[7:0];
            endcase
        end else if (off[1]) begin
            merge[31:16] = wd[15:0];
        end else begin
            merge[15:0] = wd[15:0];
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = 32'h0;
        err_d   = 1'b0;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (misaligned(req_size, req_addr[1:0]) || unmapped(req_addr)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d = req_addr[31:2];
                        if (req_we && req_size[1]) begin
                            din_d   = req_wdata;
                            state_d = WR;
                        end else begin
                            cnt_d   = RELOAD;
                            state_d = RD;
                        end
                    end
                end
            end
            RD, WAIT: begin
                // Last read cycle: the old word is on dataOutVirt at this edge
                if ((state_q == RD && cnt_q == 2'd0) || (state_q == WAIT && cnt_q == 2'd1)) begin
                    if (we_q) begin
                        din_d   = merge(dataOutVirt, wdata_q, size_q, off_q);
                        state_d = WR;
                    end else begin
                        rdata_d = extract(dataOutVirt, size_q, off_q, sgn_q);
                        state_d = RESP;
                    end
                end else begin
                    if (state_q == WAIT) cnt_d = cnt_q - 2'd1;
                    state_d = WAIT;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 30'h0;
            din_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        sgn_q   <= sgn_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
    end

    assign req_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign addressVirt = {addr_q, 2'b00};
    assign dataInVirt  = din_q;
    assign wEnVirt     = (state_q == WR);

endmodule
